// File: rtl/gpu_write_queue.sv
// rtl/gpu_write_queue.sv - command FIFO draining into single-outstanding AXI-lite writes
// Optional misaligned-address discard enabled by macro GPU_WRQ_ALIGN_CHECK_EN.
module gpu_write_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] axil_awaddr,
  output logic [2:0]            axil_awprot,
  output logic                  axil_awvalid,
  input  logic                  axil_awready,
  output logic [DATA_WIDTH-1:0] axil_wdata,
  output logic [STRB_WIDTH-1:0] axil_wstrb,
  output logic                  axil_wvalid,
  input  logic                  axil_wready,
  input  logic [1:0]            axil_bresp,
  input  logic                  axil_bvalid,
  output logic                  axil_bready,
  output logic                  busy,
  output logic [7:0]            err_count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count, count_next;
  logic                  push, pop, issue, discard;
  logic                  aw_fire, w_fire, b_fire, err_inc, busy_next;
  logic                  head_misaligned;
  logic [ADDR_WIDTH-1:0] head_addr;

  assign head_addr   = addr_mem[rd_ptr];
  assign cmd_ready   = (count != (PTR_W+1)'(DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign aw_fire     = axil_awvalid && axil_awready;
  assign w_fire      = axil_wvalid && axil_wready;
  assign b_fire      = axil_bvalid && axil_bready;
  assign axil_wstrb  = '1;
  assign axil_awprot = 3'b000;

`ifdef GPU_WRQ_ALIGN_CHECK_EN
  assign head_misaligned = (head_addr[1:0] != 2'b00);
`else
  assign head_misaligned = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    issue      = 1'b0;
    discard    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if (head_misaligned) begin
            discard = 1'b1;
          end else begin
            issue      = 1'b1;
            state_next = SEND;
          end
        end
      end
      // Each channel completes on its own handshake; leave only when both are done.
      SEND: begin
        if ((!axil_awvalid || aw_fire) && (!axil_wvalid || w_fire))
          state_next = RESP;
      end
      RESP: begin
        if (b_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    busy_next  = (count_next != '0) || (state_next != IDLE);
    err_inc    = discard || (b_fire && (axil_bresp != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cmd_addr;
      data_mem[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      axil_awaddr  <= '0;
      axil_wdata   <= '0;
      axil_awvalid <= 1'b0;
      axil_wvalid  <= 1'b0;
      axil_bready  <= 1'b0;
      busy         <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (issue) begin
        axil_awaddr  <= head_addr;
        axil_wdata   <= data_mem[rd_ptr];
        axil_awvalid <= 1'b1;
        axil_wvalid  <= 1'b1;
      end
      if (aw_fire) axil_awvalid <= 1'b0;
      if (w_fire)  axil_wvalid  <= 1'b0;
      axil_bready <= (state_next == RESP);
      busy        <= busy_next;
      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end
endmodule
